// File: rtl/usb_tx_ctrl_if.sv
// Signal bundle between usb_tx_ctrl and its requesters, payload FIFO, usb_tx and status logic.
// The controller uses the slave modport; whatever drives requests and consumes status uses master.
interface usb_tx_ctrl_if;
    logic       hs_req;
    logic       hs_nak;
    logic       hs_grant;
    logic       data_req;
    logic [6:0] data_size;
    logic       data_grant;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_data_size;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet;
    logic       tx_done;
    logic       busy;
    logic       err_underrun;
    logic       err_timeout;
    logic       err_clr;

    modport slave (
        input  hs_req, hs_nak, data_req, data_size, fifo_rdata, fifo_empty,
               get_tx_packet, tx_done, err_clr,
        output hs_grant, data_grant, fifo_pop, tx_packet, tx_packet_data_size,
               tx_packet_data, busy, err_underrun, err_timeout
    );

    modport master (
        output hs_req, hs_nak, data_req, data_size, fifo_rdata, fifo_empty,
               get_tx_packet, tx_done, err_clr,
        input  hs_grant, data_grant, fifo_pop, tx_packet, tx_packet_data_size,
               tx_packet_data, busy, err_underrun, err_timeout
    );
endinterface

// File: rtl/usb_tx_ctrl.sv
// USB transmit controller: arbitrates handshake vs data packets, streams FIFO payload to usb_tx,
// enforces an inter-packet gap and aborts packets that stay active too long.
module usb_tx_ctrl #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_SIZE       = 64
) (
    input  logic          clk,
    input  logic          n_rst,
    usb_tx_ctrl_if.slave  bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0]    PKT_NONE     = 2'b00;
    localparam logic [1:0]    PKT_DATA0    = 2'b01;
    localparam logic [1:0]    PKT_ACK      = 2'b10;
    localparam logic [1:0]    PKT_NAK      = 2'b11;
    localparam logic [6:0]    MAX_SIZE_W   = 7'(MAX_SIZE);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    tx_packet_q, tx_packet_d;
    logic [6:0]    size_q, size_d;
    logic [7:0]    data_q, data_d;
    logic [6:0]    remaining_q, remaining_d;
    logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          hs_grant_q, hs_grant_d;
    logic          data_grant_q, data_grant_d;
    logic          err_underrun_q, err_underrun_d;
    logic          err_timeout_q, err_timeout_d;

    logic          timeout_hit;
    logic          byte_service;
    logic [6:0]    clamped_size;

    assign clamped_size = (bus.data_size > MAX_SIZE_W) ? MAX_SIZE_W : bus.data_size;
    assign timeout_hit  = (timeout_cnt_q == TIMEOUT_LAST);

    // A payload byte is served only while a DATA0 packet is live and not finishing or aborting this cycle.
    assign byte_service = (state_q == ACTIVE) && (tx_packet_q == PKT_DATA0) && bus.get_tx_packet
                          && (remaining_q != 7'd0) && !bus.tx_done && !timeout_hit;

    always_comb begin
        state_d        = state_q;
        tx_packet_d    = tx_packet_q;
        size_d         = size_q;
        data_d         = data_q;
        remaining_d    = remaining_q;
        timeout_cnt_d  = timeout_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        hs_grant_d     = 1'b0;
        data_grant_d   = 1'b0;
        err_underrun_d = err_underrun_q & ~bus.err_clr;
        err_timeout_d  = err_timeout_q & ~bus.err_clr;

        case (state_q)
            IDLE: begin
                if (bus.hs_req) begin
                    hs_grant_d    = 1'b1;
                    tx_packet_d   = bus.hs_nak ? PKT_NAK : PKT_ACK;
                    size_d        = 7'd0;
                    remaining_d   = 7'd0;
                    timeout_cnt_d = '0;
                    state_d       = ACTIVE;
                end else if (bus.data_req) begin
                    data_grant_d  = 1'b1;
                    tx_packet_d   = PKT_DATA0;
                    size_d        = clamped_size;
                    remaining_d   = clamped_size;
                    timeout_cnt_d = '0;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.tx_done) begin
                    tx_packet_d = PKT_NONE;
                    gap_cnt_d   = GAP_LAST;
                    state_d     = GAP;
                end else if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    tx_packet_d   = PKT_NONE;
                    gap_cnt_d     = GAP_LAST;
                    state_d       = GAP;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                    if (byte_service) begin
                        remaining_d = remaining_q - 7'd1;
                        if (bus.fifo_empty) begin
                            data_d         = 8'h00;
                            err_underrun_d = 1'b1;
                        end else begin
                            data_d = bus.fifo_rdata;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            tx_packet_q    <= PKT_NONE;
            size_q         <= 7'd0;
            data_q         <= 8'h00;
            remaining_q    <= 7'd0;
            timeout_cnt_q  <= '0;
            gap_cnt_q      <= '0;
            hs_grant_q     <= 1'b0;
            data_grant_q   <= 1'b0;
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_packet_q    <= tx_packet_d;
            size_q         <= size_d;
            data_q         <= data_d;
            remaining_q    <= remaining_d;
            timeout_cnt_q  <= timeout_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            hs_grant_q     <= hs_grant_d;
            data_grant_q   <= data_grant_d;
            err_underrun_q <= err_underrun_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.hs_grant            = hs_grant_q;
    assign bus.data_grant          = data_grant_q;
    assign bus.fifo_pop            = byte_service && !bus.fifo_empty;
    assign bus.tx_packet           = tx_packet_q;
    assign bus.tx_packet_data_size = size_q;
    assign bus.tx_packet_data      = data_q;
    assign bus.busy                = (state_q != IDLE);
    assign bus.err_underrun        = err_underrun_q;
    assign bus.err_timeout         = err_timeout_q;
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Self-checking bench for usb_tx_ctrl: packet types/sizes and payload bytes are queued when
// requested and compared when the controller grants or delivers them.
module tb_usb_tx_ctrl;
    localparam int GAP  = 4;
    localparam int TMO  = 32;
    localparam int MAXS = 64;

    typedef struct packed {
        logic [1:0] pkt;
        logic [6:0] size;
    } pkt_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pkt_t       pkt_q[$];
    logic [7:0] byte_q[$];

    logic [7:0] fifo_mem [0:15];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    int         pop_cnt = 0;

    always #5 clk = ~clk;

    usb_tx_ctrl_if ifc();

    usb_tx_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_SIZE(MAXS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifc)
    );

    assign ifc.fifo_empty = (fifo_wr == fifo_rd);
    assign ifc.fifo_rdata = fifo_mem[fifo_rd[3:0]];

    always @(posedge clk) begin
        if (ifc.fifo_pop === 1'b1 && fifo_wr != fifo_rd) begin
            fifo_rd <= fifo_rd + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [7:0] b);
        fifo_mem[fifo_wr[3:0]] = b;
        fifo_wr++;
    endtask

    task automatic wait_hs_grant(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ifc.hs_grant === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_data_grant(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ifc.data_grant === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (ifc.busy === 1'b0) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic end_packet(output bit ok);
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_reset();
        tick(); tick();
        tests_run++; if (ifc.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
        tests_run++; if (ifc.tx_packet !== 2'b00) begin tests_failed++; $display("FAIL rst_tx_packet got=%b exp=00", ifc.tx_packet); end
        tests_run++; if (ifc.tx_packet_data_size !== 7'd0) begin tests_failed++; $display("FAIL rst_size got=%0d exp=0", ifc.tx_packet_data_size); end
        tests_run++; if (ifc.tx_packet_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data got=%h exp=00", ifc.tx_packet_data); end
        tests_run++; if ({ifc.hs_grant, ifc.data_grant, ifc.fifo_pop} !== 3'b000) begin tests_failed++; $display("FAIL rst_strobes got=%b exp=000", {ifc.hs_grant, ifc.data_grant, ifc.fifo_pop}); end
        tests_run++; if ({ifc.err_underrun, ifc.err_timeout} !== 2'b00) begin tests_failed++; $display("FAIL rst_errors got=%b exp=00", {ifc.err_underrun, ifc.err_timeout}); end
        n_rst = 1'b1;
        tick();
        tests_run++; if (ifc.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_busy got=%b exp=0", ifc.busy); end
        $display("[TB] reset checked");
    endtask

    task automatic test_handshake_nak();
        bit seen, ok;
        int busy_cycles;
        pkt_t exp;
        ifc.hs_nak = 1'b1;
        ifc.hs_req = 1'b1;
        pkt_q.push_back(pkt_t'{2'b11, 7'd0});
        wait_hs_grant(seen);
        ifc.hs_req = 1'b0;
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL nak_grant got=0 exp=1"); end
        exp = pkt_q.pop_front();
        tests_run++; if (ifc.tx_packet !== exp.pkt) begin tests_failed++; $display("FAIL nak_packet got=%b exp=%b", ifc.tx_packet, exp.pkt); end
        tests_run++; if (ifc.tx_packet_data_size !== exp.size) begin tests_failed++; $display("FAIL nak_size got=%0d exp=%0d", ifc.tx_packet_data_size, exp.size); end
        tests_run++; if (ifc.busy !== 1'b1) begin tests_failed++; $display("FAIL nak_busy got=%b exp=1", ifc.busy); end
        tick();
        tests_run++; if (ifc.hs_grant !== 1'b0) begin tests_failed++; $display("FAIL nak_grant_pulse got=%b exp=0", ifc.hs_grant); end
        repeat (3) tick();
        tests_run++; if (ifc.tx_packet !== 2'b11) begin tests_failed++; $display("FAIL nak_stable got=%b exp=11", ifc.tx_packet); end
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
        tests_run++; if (ifc.tx_packet !== 2'b00) begin tests_failed++; $display("FAIL nak_after_done got=%b exp=00", ifc.tx_packet); end
        busy_cycles = 0;
        for (int i = 0; i < 50 && ifc.busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        tests_run++; if (busy_cycles != GAP) begin tests_failed++; $display("FAIL nak_gap_len got=%0d exp=%0d", busy_cycles, GAP); end
        wait_idle(ok);
        $display("[TB] NAK handshake sent, gap busy cycles=%0d", busy_cycles);
    endtask

    task automatic test_data_packet();
        bit seen, ok;
        pkt_t exp;
        int pop_start;
        logic exp_pop;
        logic [7:0] exp_b;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        for (int i = 0; i < 3; i++) push_fifo(bytes[i]);
        ifc.data_size = 7'd3;
        ifc.data_req  = 1'b1;
        pkt_q.push_back(pkt_t'{2'b01, 7'd3});
        wait_data_grant(seen);
        ifc.data_req = 1'b0;
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL data_grant got=0 exp=1"); end
        exp = pkt_q.pop_front();
        tests_run++; if ({ifc.tx_packet, ifc.tx_packet_data_size} !== {exp.pkt, exp.size}) begin tests_failed++; $display("FAIL data_header got=%b/%0d exp=%b/%0d", ifc.tx_packet, ifc.tx_packet_data_size, exp.pkt, exp.size); end
        pop_start = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_pop = (k < 3);
            ifc.get_tx_packet = 1'b1;
            if (k < 3) byte_q.push_back(bytes[k]);
            #1;
            tests_run++; if (ifc.fifo_pop !== exp_pop) begin tests_failed++; $display("FAIL data_pop%0d got=%b exp=%b", k, ifc.fifo_pop, exp_pop); end
            tick();
            ifc.get_tx_packet = 1'b0;
            exp_b = (k < 3) ? byte_q.pop_front() : 8'hC3;
            tests_run++; if (ifc.tx_packet_data !== exp_b) begin tests_failed++; $display("FAIL data_byte%0d got=%h exp=%h", k, ifc.tx_packet_data, exp_b); end
            $display("[TB] data get %0d -> byte %h", k, ifc.tx_packet_data);
            tick();
        end
        tests_run++; if (pop_cnt - pop_start != 3) begin tests_failed++; $display("FAIL data_pop_count got=%0d exp=3", pop_cnt - pop_start); end
        end_packet(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL data_return_idle got=busy exp=idle"); end
    endtask

    task automatic test_priority();
        bit seen, ok, early;
        pkt_t exp;
        push_fifo(8'h5A);
        ifc.hs_nak    = 1'b0;
        ifc.hs_req    = 1'b1;
        ifc.data_size = 7'd1;
        ifc.data_req  = 1'b1;
        pkt_q.push_back(pkt_t'{2'b10, 7'd0});
        pkt_q.push_back(pkt_t'{2'b01, 7'd1});
        wait_hs_grant(seen);
        ifc.hs_req = 1'b0;
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL prio_hs_grant got=0 exp=1"); end
        tests_run++; if (ifc.data_grant !== 1'b0) begin tests_failed++; $display("FAIL prio_single_grant got=%b exp=0", ifc.data_grant); end
        exp = pkt_q.pop_front();
        tests_run++; if (ifc.tx_packet !== exp.pkt) begin tests_failed++; $display("FAIL prio_ack got=%b exp=%b", ifc.tx_packet, exp.pkt); end
        tick();
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
        early = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            if (ifc.data_grant !== 1'b0 || ifc.busy !== 1'b1) early = 1'b1;
            tick();
        end
        tests_run++; if (early) begin tests_failed++; $display("FAIL prio_grant_in_gap got=early exp=after_gap"); end
        wait_data_grant(seen);
        ifc.data_req = 1'b0;
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL prio_data_grant got=0 exp=1"); end
        exp = pkt_q.pop_front();
        tests_run++; if ({ifc.tx_packet, ifc.tx_packet_data_size} !== {exp.pkt, exp.size}) begin tests_failed++; $display("FAIL prio_data_header got=%b/%0d exp=%b/%0d", ifc.tx_packet, ifc.tx_packet_data_size, exp.pkt, exp.size); end
        ifc.get_tx_packet = 1'b1;
        byte_q.push_back(8'h5A);
        tick();
        ifc.get_tx_packet = 1'b0;
        exp.pkt = 2'b00;
        tests_run++; if (ifc.tx_packet_data !== byte_q[0]) begin tests_failed++; $display("FAIL prio_byte got=%h exp=%h", ifc.tx_packet_data, byte_q[0]); end
        void'(byte_q.pop_front());
        end_packet(ok);
        $display("[TB] ACK then DATA0 sent in priority order");
    endtask

    task automatic test_underrun();
        bit seen, ok;
        pkt_t exp;
        push_fifo(8'h77);
        ifc.data_size = 7'd2;
        ifc.data_req  = 1'b1;
        pkt_q.push_back(pkt_t'{2'b01, 7'd2});
        wait_data_grant(seen);
        ifc.data_req = 1'b0;
        exp = pkt_q.pop_front();
        tests_run++; if (!seen || ifc.tx_packet_data_size !== exp.size) begin tests_failed++; $display("FAIL urun_header got=%b/%0d exp=1/%0d", seen, ifc.tx_packet_data_size, exp.size); end
        ifc.get_tx_packet = 1'b1;
        byte_q.push_back(8'h77);
        tick();
        ifc.get_tx_packet = 1'b0;
        tests_run++; if (ifc.tx_packet_data !== byte_q[0]) begin tests_failed++; $display("FAIL urun_byte0 got=%h exp=%h", ifc.tx_packet_data, byte_q[0]); end
        void'(byte_q.pop_front());
        tests_run++; if (ifc.err_underrun !== 1'b0) begin tests_failed++; $display("FAIL urun_early got=%b exp=0", ifc.err_underrun); end
        tick();
        ifc.get_tx_packet = 1'b1;
        byte_q.push_back(8'h00);
        #1;
        tests_run++; if (ifc.fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL urun_no_pop got=%b exp=0", ifc.fifo_pop); end
        tick();
        ifc.get_tx_packet = 1'b0;
        tests_run++; if (ifc.tx_packet_data !== byte_q[0]) begin tests_failed++; $display("FAIL urun_byte1 got=%h exp=%h", ifc.tx_packet_data, byte_q[0]); end
        void'(byte_q.pop_front());
        tests_run++; if (ifc.err_underrun !== 1'b1) begin tests_failed++; $display("FAIL urun_flag got=%b exp=1", ifc.err_underrun); end
        end_packet(ok);
        tests_run++; if (ifc.err_underrun !== 1'b1) begin tests_failed++; $display("FAIL urun_sticky got=%b exp=1", ifc.err_underrun); end
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        tests_run++; if (ifc.err_underrun !== 1'b0) begin tests_failed++; $display("FAIL urun_clear got=%b exp=0", ifc.err_underrun); end
        $display("[TB] underrun packet sent, flag set and cleared");
    endtask

    task automatic test_timeout();
        bit seen, ok;
        int cnt;
        pkt_t exp;
        ifc.data_size = 7'd100;
        ifc.data_req  = 1'b1;
        pkt_q.push_back(pkt_t'{2'b01, 7'(MAXS)});
        wait_data_grant(seen);
        ifc.data_req = 1'b0;
        exp = pkt_q.pop_front();
        tests_run++; if (!seen || ifc.tx_packet_data_size !== exp.size) begin tests_failed++; $display("FAIL tmo_clamp got=%b/%0d exp=1/%0d", seen, ifc.tx_packet_data_size, exp.size); end
        cnt = 0;
        while (cnt < TMO + 10 && ifc.err_timeout !== 1'b1) begin
            tick();
            cnt++;
        end
        tests_run++; if (cnt != TMO) begin tests_failed++; $display("FAIL tmo_cycles got=%0d exp=%0d", cnt, TMO); end
        tests_run++; if ({ifc.tx_packet, ifc.busy} !== 3'b001) begin tests_failed++; $display("FAIL tmo_abort got=%b/%b exp=00/1", ifc.tx_packet, ifc.busy); end
        wait_idle(ok);
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
        tests_run++; if (ifc.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_clear got=%b exp=0", ifc.err_timeout); end
        $display("[TB] DATA0 size 100 clamped and timed out after %0d cycles", cnt);

        ifc.hs_nak = 1'b0;
        ifc.hs_req = 1'b1;
        pkt_q.push_back(pkt_t'{2'b10, 7'd0});
        wait_hs_grant(seen);
        ifc.hs_req = 1'b0;
        exp = pkt_q.pop_front();
        repeat (TMO - 1) tick();
        tests_run++; if ({ifc.tx_packet, ifc.busy} !== {exp.pkt, 1'b1}) begin tests_failed++; $display("FAIL tmo_edge_active got=%b/%b exp=%b/1", ifc.tx_packet, ifc.busy, exp.pkt); end
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
        tests_run++; if (ifc.err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_done_wins got=%b exp=0", ifc.err_timeout); end
        tests_run++; if ({ifc.tx_packet, ifc.busy} !== 3'b001) begin tests_failed++; $display("FAIL tmo_done_gap got=%b/%b exp=00/1", ifc.tx_packet, ifc.busy); end
        wait_idle(ok);
        $display("[TB] ACK with tx_done on last timeout cycle finished cleanly");
    endtask

    task automatic test_reset_mid();
        bit seen, ok;
        pkt_t exp;
        push_fifo(8'h9C);
        ifc.data_size = 7'd3;
        ifc.data_req  = 1'b1;
        wait_data_grant(seen);
        ifc.data_req = 1'b0;
        ifc.get_tx_packet = 1'b1;
        tick();
        ifc.get_tx_packet = 1'b0;
        tests_run++; if (ifc.tx_packet_data !== 8'h9C) begin tests_failed++; $display("FAIL rmid_byte got=%h exp=9c", ifc.tx_packet_data); end
        ifc.hs_nak = 1'b0;
        ifc.hs_req = 1'b1;
        n_rst = 1'b0;
        #1;
        tests_run++; if ({ifc.busy, ifc.tx_packet, ifc.tx_packet_data_size, ifc.tx_packet_data} !== 18'd0) begin tests_failed++; $display("FAIL rmid_async got=%b/%b/%0d/%h exp=0/00/0/00", ifc.busy, ifc.tx_packet, ifc.tx_packet_data_size, ifc.tx_packet_data); end
        tick(); tick();
        tests_run++; if ({ifc.hs_grant, ifc.data_grant, ifc.fifo_pop} !== 3'b000) begin tests_failed++; $display("FAIL rmid_held got=%b exp=000", {ifc.hs_grant, ifc.data_grant, ifc.fifo_pop}); end
        n_rst = 1'b1;
        pkt_q.push_back(pkt_t'{2'b10, 7'd0});
        tick();
        exp = pkt_q.pop_front();
        tests_run++; if (ifc.hs_grant !== 1'b1) begin tests_failed++; $display("FAIL rmid_first_grant got=%b exp=1", ifc.hs_grant); end
        tests_run++; if (ifc.tx_packet !== exp.pkt) begin tests_failed++; $display("FAIL rmid_packet got=%b exp=%b", ifc.tx_packet, exp.pkt); end
        ifc.hs_req = 1'b0;
        end_packet(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmid_idle got=busy exp=idle"); end
        $display("[TB] reset mid-packet abandoned DATA0, pending ACK granted after release");
    endtask

    initial begin
        ifc.hs_req        = 1'b0;
        ifc.hs_nak        = 1'b0;
        ifc.data_req      = 1'b0;
        ifc.data_size     = 7'd0;
        ifc.get_tx_packet = 1'b0;
        ifc.tx_done       = 1'b0;
        ifc.err_clr       = 1'b0;
        for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;
        test_reset();
        test_handshake_nak();
        test_data_packet();
        test_priority();
        test_underrun();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
